bit_gatherer: RTL and testbench

Receiving end of the serial bit-enumeration interface driven by `main`. `main` walks a byte and presents one bit per cycle on `b`, with its index on `s`, qualified by `active`. This block re-assembles those bits into a byte, or counts the ones among them. It uses the same `on`/`start`/`regime` command style as `main`, so one controller can drive both ends.

---
 rtl/bit_gatherer.sv | 155 +++++++++++++++
 tb/tb_bit_gatherer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_gatherer.sv
// Serial bit gatherer: re-assembles indexed bits into a word, or counts the ones among them.
// Optional index checking and index-addressed writes are enabled by defining BIT_GATHER_INDEX_CHECK_EN.
module bit_gatherer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b,
  input  logic [IDX_W-1:0] s,
  input  logic             active,
  input  logic [1:0]       on,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       regime,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       CMD_GATHER = 2'd1;
  localparam logic [1:0]       CMD_COUNT  = 2'd2;
  localparam logic [1:0]       CMD_CLEAR  = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       regime_q, regime_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] wr_idx_s;
  logic             mismatch_s;

`ifdef BIT_GATHER_INDEX_CHECK_EN
  assign wr_idx_s   = s;
  assign mismatch_s = (s != exp_q);
`else
  logic unused_s;
  assign unused_s   = ^s;
  assign wr_idx_s   = exp_q;
  assign mismatch_s = 1'b0;
`endif

  // Next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    regime_d = regime_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        case (on)
          CMD_GATHER, CMD_COUNT: regime_d = on;
          CMD_CLEAR: begin
            y_d      = {WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            err_d    = 1'b0;
            regime_d = 2'd0;
          end
          default: regime_d = regime_q;
        endcase
        // The run decision looks at the regime latched before this cycle
        if (start && ((regime_q == CMD_GATHER) || (regime_q == CMD_COUNT))) begin
          state_d = ST_RUN;
          exp_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (active) begin
          if (regime_q == CMD_GATHER) begin
            y_d[wr_idx_s] = b;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(b);
          end else begin
            cnt_d = cnt_q;
          end
          if (mismatch_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          exp_d = exp_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          exp_d = exp_q;
        end
        // Completion takes priority over an abort in the same cycle
        if (active && (exp_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end else if (!start) begin
          state_d = ST_IDLE;
          exp_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        regime_d = 2'd0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        exp_d   = {IDX_W{1'b0}};
      end
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      exp_q    <= {IDX_W{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      regime_q <= 2'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      regime_q <= regime_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign y      = y_q;
  assign cnt    = cnt_q;
  assign regime = regime_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bit_gatherer.sv
// Scoreboard bench for bit_gatherer: completions are checked by a done-driven monitor,
// with direct checks for reset, abort, busy length and asynchronous reset.
module tb_bit_gatherer;

  typedef struct {
    logic [7:0] y;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  logic       clk, rst, b, active, start;
  logic [2:0] s;
  logic [1:0] on;
  logic [7:0] y;
  logic [3:0] cnt;
  logic [1:0] regime;
  logic       busy, done, err;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit_gatherer #(.WIDTH(8), .IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .b(b), .s(s), .active(active), .on(on), .start(start),
    .y(y), .cnt(cnt), .regime(regime), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic bb, input logic [2:0] ss);
    active = 1'b1;
    b      = bb;
    s      = ss;
    step();
    active = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] c);
    on = c;
    step();
    on = 2'd0;
  endtask

  task automatic push(input logic [7:0] ey, input logic [3:0] ec, input logic ee);
    exp_t e;
    e.y   = ey;
    e.cnt = ec;
    e.err = ee;
    sb_q.push_back(e);
  endtask

  // Monitor: every done pulse consumes one expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_y", 32'(y), 32'(e.y));
        chk("done_cnt", 32'(cnt), 32'(e.cnt));
        chk("done_err", 32'(err), 32'(e.err));
      end
    end
  end

  logic [7:0] gbits;
  logic [2:0] seq_s [8];
  int         busy_cnt;
  logic [7:0] idx_y;
  logic       idx_err;

  initial begin
    rst = 1'b1; b = 1'b0; s = 3'd0; active = 1'b0; on = 2'd0; start = 1'b0;
    repeat (2) step();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_regime", 32'(regime), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    step();

    // Clear in IDLE
    cmd(2'd3);
    chk("clr_y", 32'(y), 32'h0);
    chk("clr_cnt", 32'(cnt), 32'h0);
    chk("clr_regime", 32'(regime), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);

    // Gather 0x39: bits in order 1,0,0,1,1,1,0,0
    gbits = 8'h39;
    cmd(2'd1);
    chk("gat_regime", 32'(regime), 32'd1);
    start = 1'b1;
    step();
    chk("gat_busy", 32'(busy), 32'd1);
    push(8'h39, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) feed(gbits[i], 3'(i));
    chk("gat_done_now", 32'(done), 32'd1);
    step();
    chk("gat_regime_after", 32'(regime), 32'd0);
    chk("gat_idle", 32'(busy), 32'd0);
    step();
    chk("gat_no_restart", 32'(busy), 32'd0);
    start = 1'b0;

    // Count with active on alternate cycles
    cmd(2'd3);
    cmd(2'd2);
    start = 1'b1;
    step();
    push(8'h00, 4'd4, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy) busy_cnt++;
      active = (i % 2 == 1);
      b      = gbits[i/2];
      s      = 3'(i/2);
      step();
    end
    active = 1'b0;
    chk("cnt_busy_cycles", 32'(busy_cnt), 32'd16);
    step();
    start = 1'b0;
    step();

    // Abort a gather of 0xFF after three bits
    cmd(2'd1);
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) feed(1'b1, 3'(i));
    start = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_y", 32'(y), 32'h07);
    repeat (3) step();
    cmd(2'd1);
    start = 1'b1;
    step();
    push(8'h00, 4'd4, 1'b0);
    for (int i = 0; i < 8; i++) feed(1'b0, 3'(i));
    step();
    start = 1'b0;
    step();

    // Out-of-order indices 0,1,3,2,4,5,6,7 with b = s[0]
`ifdef BIT_GATHER_INDEX_CHECK_EN
    idx_y = 8'hAA; idx_err = 1'b1;
`else
    idx_y = 8'hA6; idx_err = 1'b0;
`endif
    seq_s = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    cmd(2'd3);
    cmd(2'd1);
    start = 1'b1;
    step();
    push(idx_y, 4'd0, idx_err);
    for (int i = 0; i < 8; i++) begin
      feed(seq_s[i][0], seq_s[i]);
      if (i == 2) chk("idx_err_bit3", 32'(err), 32'(idx_err));
    end
    step();
    start = 1'b0;
    step();

    // Asynchronous reset in the middle of a run
    cmd(2'd3);
    cmd(2'd1);
    start = 1'b1;
    step();
    for (int i = 0; i < 5; i++) feed(1'b1, 3'(i));
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_regime", 32'(regime), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    start = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
